// File: rtl/mips_run_pkg.sv
// Shared types and constants for the MIPS run controller and its dump readers.
package mips_run_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RUN     = 3'd2,
        DRAIN   = 3'd3,
        DUMP    = 3'd4,
        REGDUMP = 3'd5,
        DONE    = 3'd6
    } run_state_t;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_ISSUE = 2'd1,
        RD_HOLD  = 2'd2
    } rd_state_t;

    localparam int REGDUMP_BASE = 128;
    localparam int WORD_SHIFT   = 2;

endpackage

// File: rtl/run_dump_reader.sv
// Read-issue / capture / hold engine: walks WORDS addresses of a memory whose
// read data is ready by the edge after the address, and streams them out valid/ready.
module run_dump_reader
    import mips_run_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int WORDS    = 32,
    parameter int IDX_BASE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    output logic [7:0]        word,
    input  logic [DATA_W-1:0] rdata,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [7:0]        idx,
    input  logic              ready,
    output logic              last
);

    rd_state_t st;

    // Valid/ready: a word transfers on a rising edge where valid and ready are both
    // high; data/idx/valid are held unchanged until then, and ready is ignored otherwise.
    assign last = (st == RD_HOLD) && ready && (word == 8'(WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st    <= RD_IDLE;
            word  <= '0;
            valid <= 1'b0;
            data  <= '0;
            idx   <= '0;
        end else begin
            case (st)
                RD_IDLE: begin
                    if (go) begin
                        word <= '0;
                        st   <= RD_ISSUE;
                    end
                end
                RD_ISSUE: begin
                    data  <= rdata;
                    idx   <= 8'(IDX_BASE) + word;
                    valid <= 1'b1;
                    st    <= RD_HOLD;
                end
                RD_HOLD: begin
                    if (ready) begin
                        valid <= 1'b0;
                        if (last) begin
                            st <= RD_IDLE;
                        end else begin
                            word <= word + 8'd1;
                            st   <= RD_ISSUE;
                        end
                    end
                end
                default: st <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller for the MIPS core: load imem, run to END_PC, drain, dump dmem.
// Define RUN_CTRL_REGDUMP_EN to also stream the register file after the data dump.
module mips_run_ctrl
    import mips_run_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int PC_W       = 32,
    parameter int IMEM_DEPTH = 64,
    parameter int END_PC     = 136,
    parameter int DRAIN_CYC  = 2,
    parameter int TIMEOUT    = 4096,
    parameter int DUMP_WORDS = 32
) (
    input  logic              clk,
    input  logic              start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic              ld_last,
    output logic              im_we,
    output logic [PC_W-1:0]   im_waddr,
    output logic [DATA_W-1:0] im_wdata,
    output logic              cpu_start,
    input  logic [PC_W-1:0]   cpu_pc,
    output logic [PC_W-1:0]   dm_raddr,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              dump_valid,
    output logic [DATA_W-1:0] dump_data,
    output logic [7:0]        dump_idx,
    input  logic              dump_ready,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              load_err,
    output logic [31:0]       cycles,
    output logic [2:0]        run_state
`ifdef RUN_CTRL_REGDUMP_EN
    ,
    output logic [4:0]        rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata
`endif
);

    localparam int CW = $clog2(IMEM_DEPTH) + 1;
    localparam int DW = $clog2(DRAIN_CYC + 2);

    run_state_t     state;
    logic [CW-1:0]  count;
    logic [DW-1:0]  drain;
    logic [31:0]    cycles_inc;

    logic [7:0]        dm_word;
    logic              dm_valid;
    logic [DATA_W-1:0] dm_data;
    logic [7:0]        dm_idx;
    logic              dm_last;

    assign ld_ready   = (state == LOAD) && (count < CW'(IMEM_DEPTH));
    assign im_we      = ld_valid && ld_ready;
    assign im_waddr   = im_we ? (PC_W'(count) << WORD_SHIFT) : '0;
    assign im_wdata   = im_we ? ld_data : '0;
    // Derived from the state register so it drops together with the async reset.
    assign cpu_start  = (state == RUN) || (state == DRAIN);
    assign busy       = (state != IDLE) && (state != DONE);
    assign run_state  = state;
    assign cycles_inc = (cycles == '1) ? cycles : cycles + 32'd1;
    assign dm_raddr   = PC_W'(dm_word) << WORD_SHIFT;

    run_dump_reader #(
        .DATA_W  (DATA_W),
        .WORDS   (DUMP_WORDS),
        .IDX_BASE(0)
    ) u_dm_reader (
        .clk  (clk),
        .rst_n(start),
        .go   (state == DUMP),
        .word (dm_word),
        .rdata(dm_rdata),
        .valid(dm_valid),
        .data (dm_data),
        .idx  (dm_idx),
        .ready(dump_ready && (state == DUMP)),
        .last (dm_last)
    );

`ifdef RUN_CTRL_REGDUMP_EN
    logic [7:0]        rf_word;
    logic              rf_valid;
    logic [DATA_W-1:0] rf_data;
    logic [7:0]        rf_idx;
    logic              rf_last;

    run_dump_reader #(
        .DATA_W  (DATA_W),
        .WORDS   (32),
        .IDX_BASE(REGDUMP_BASE)
    ) u_rf_reader (
        .clk  (clk),
        .rst_n(start),
        .go   (state == REGDUMP),
        .word (rf_word),
        .rdata(rf_rdata),
        .valid(rf_valid),
        .data (rf_data),
        .idx  (rf_idx),
        .ready(dump_ready && (state == REGDUMP)),
        .last (rf_last)
    );

    assign rf_raddr   = rf_word[4:0];
    assign dump_valid = dm_valid || rf_valid;
    assign dump_data  = rf_valid ? rf_data : dm_data;
    assign dump_idx   = rf_valid ? rf_idx : dm_idx;
`else
    assign dump_valid = dm_valid;
    assign dump_data  = dm_data;
    assign dump_idx   = dm_idx;
`endif

    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            state    <= IDLE;
            count    <= '0;
            drain    <= '0;
            cycles   <= '0;
            done     <= 1'b0;
            timeout  <= 1'b0;
            load_err <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= LOAD;
                LOAD: begin
                    if (im_we) begin
                        count <= count + CW'(1);
                        if (ld_last) state <= RUN;
                    end else if (ld_valid && (count == CW'(IMEM_DEPTH))) begin
                        load_err <= 1'b1;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                RUN: begin
                    cycles <= cycles_inc;
                    // Timeout takes priority over reaching END_PC in the same cycle.
                    if (cycles_inc >= 32'(TIMEOUT)) begin
                        timeout <= 1'b1;
                        state   <= DUMP;
                    end else if (cpu_pc == PC_W'(END_PC)) begin
                        if (DRAIN_CYC == 0) begin
                            state <= DUMP;
                        end else begin
                            drain <= DW'(DRAIN_CYC);
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    cycles <= cycles_inc;
                    drain  <= drain - DW'(1);
                    if (drain == DW'(1)) state <= DUMP;
                end
                DUMP: begin
                    if (dm_last) begin
`ifdef RUN_CTRL_REGDUMP_EN
                        state <= REGDUMP;
`else
                        done  <= 1'b1;
                        state <= DONE;
`endif
                    end
                end
`ifdef RUN_CTRL_REGDUMP_EN
                REGDUMP: begin
                    if (rf_last) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
`endif
                DONE: state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
